// File: rtl/fp_div_arbiter.sv
// Round-robin front end sharing one pipelined FP divider between NUM_REQ requesters.
// Results are steered by tag into per-requester FIFOs, and credits keep a FIFO slot free for every issued op.
module fp_div_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int FP_WIDTH   = 32,
  parameter int RND_WIDTH  = 3,
  parameter int STAT_WIDTH = 8,
  parameter int RES_DEPTH  = 2,
  parameter int ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  input  logic [NUM_REQ*FP_WIDTH-1:0]    req_op_a_i,
  input  logic [NUM_REQ*FP_WIDTH-1:0]    req_op_b_i,
  input  logic [NUM_REQ*RND_WIDTH-1:0]   req_rnd_i,
  output logic [NUM_REQ-1:0]             resp_valid_o,
  input  logic [NUM_REQ-1:0]             resp_ready_i,
  output logic [NUM_REQ*FP_WIDTH-1:0]    resp_res_o,
  output logic [NUM_REQ*STAT_WIDTH-1:0]  resp_status_o,
  output logic                           div_en_o,
  output logic [FP_WIDTH-1:0]            div_op_a_o,
  output logic [FP_WIDTH-1:0]            div_op_b_o,
  output logic [RND_WIDTH-1:0]           div_rnd_o,
  output logic [ID_WIDTH-1:0]            div_tag_o,
  input  logic                           div_valid_i,
  input  logic [FP_WIDTH-1:0]            div_res_i,
  input  logic [STAT_WIDTH-1:0]          div_status_i,
  input  logic [ID_WIDTH-1:0]            div_tag_i
);
  localparam int CW = $clog2(RES_DEPTH + 1);
  localparam int PW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam int DW = FP_WIDTH + STAT_WIDTH;

  logic                active;
  logic [ID_WIDTH-1:0] rr_ptr;
  logic [CW-1:0]       credit [NUM_REQ];
  logic [CW-1:0]       count  [NUM_REQ];
  logic [PW-1:0]       rd_ptr [NUM_REQ];
  logic [PW-1:0]       wr_ptr [NUM_REQ];
  logic [DW-1:0]       mem    [NUM_REQ][RES_DEPTH];
  logic [NUM_REQ-1:0]  eligible, grant, pop, push;
  logic [ID_WIDTH-1:0] gnt_idx;
  logic                gnt_any;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (int'(p) == RES_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  // active gates grants so nothing is issued while reset is held or in the release cycle
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = active && req_valid_i[i] && (credit[i] != '0);
      pop[i]      = resp_valid_o[i] && resp_ready_i[i];
      push[i]     = div_valid_i && (int'(div_tag_i) == i) &&
                    ((count[i] != CW'(RES_DEPTH)) || pop[i]);
    end
  end

  always_comb begin : arb
    int idx;
    idx     = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    grant   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!gnt_any && eligible[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = ID_WIDTH'(idx);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) grant[i] = gnt_any && (int'(gnt_idx) == i);
  end

  assign req_ready_o = grant;
  assign div_en_o    = gnt_any;
  assign div_tag_o   = gnt_idx;
  assign div_op_a_o  = gnt_any ? req_op_a_i[gnt_idx*FP_WIDTH +: FP_WIDTH]  : '0;
  assign div_op_b_o  = gnt_any ? req_op_b_i[gnt_idx*FP_WIDTH +: FP_WIDTH]  : '0;
  assign div_rnd_o   = gnt_any ? req_rnd_i[gnt_idx*RND_WIDTH +: RND_WIDTH] : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active <= 1'b0;
      rr_ptr <= '0;
      for (int i = 0; i < NUM_REQ; i++) credit[i] <= CW'(RES_DEPTH);
    end else begin
      active <= 1'b1;
      if (gnt_any) rr_ptr <= (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i] && !pop[i])      credit[i] <= credit[i] - 1'b1;
        else if (!grant[i] && pop[i]) credit[i] <= credit[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        count[i]  <= '0;
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (push[i]) wr_ptr[i] <= ptr_inc(wr_ptr[i]);
        if (pop[i])  rd_ptr[i] <= ptr_inc(rd_ptr[i]);
        if (push[i] && !pop[i])      count[i] <= count[i] + 1'b1;
        else if (!push[i] && pop[i]) count[i] <= count[i] - 1'b1;
      end
    end
  end

  // storage needs no reset: the head is masked to zero whenever the FIFO is empty
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NUM_REQ; i++)
      if (push[i]) mem[i][wr_ptr[i]] <= {div_res_i, div_status_i};
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_out
    assign resp_valid_o[i] = (count[i] != '0);
    assign resp_res_o[i*FP_WIDTH +: FP_WIDTH] =
      resp_valid_o[i] ? mem[i][rd_ptr[i]][DW-1:STAT_WIDTH] : '0;
    assign resp_status_o[i*STAT_WIDTH +: STAT_WIDTH] =
      resp_valid_o[i] ? mem[i][rd_ptr[i]][STAT_WIDTH-1:0] : '0;

    a_credit_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
      credit[i] <= CW'(RES_DEPTH));
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (div_valid_i && int'(div_tag_i) == i) |-> ((count[i] != CW'(RES_DEPTH)) || pop[i]));
  end

  a_tag_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
    div_valid_i |-> (int'(div_tag_i) < NUM_REQ));

endmodule

// File: tb/tb_fp_div_arbiter.sv
// Bench for fp_div_arbiter: 3-cycle divider model, queue-driven requesters, and a
// scoreboard filled at grant time and drained by a response monitor.
module tb_fp_div_arbiter;
  localparam int NR = 4, FW = 32, RW = 3, SW = 8, RD = 2, IW = 2, L = 3;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic [NR-1:0]    req_valid, req_ready, resp_valid, resp_ready;
  logic [NR*FW-1:0] req_op_a, req_op_b, resp_res;
  logic [NR*RW-1:0] req_rnd;
  logic [NR*SW-1:0] resp_status;
  logic             div_en, div_valid;
  logic [FW-1:0]    div_op_a, div_op_b, div_res;
  logic [RW-1:0]    div_rnd;
  logic [IW-1:0]    div_tag, div_tag_ret;
  logic [SW-1:0]    div_status;

  always #5 clk_i = ~clk_i;

  fp_div_arbiter #(.NUM_REQ(NR), .FP_WIDTH(FW), .RND_WIDTH(RW), .STAT_WIDTH(SW), .RES_DEPTH(RD)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_op_a_i(req_op_a), .req_op_b_i(req_op_b), .req_rnd_i(req_rnd),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_res_o(resp_res), .resp_status_o(resp_status),
    .div_en_o(div_en), .div_op_a_o(div_op_a), .div_op_b_o(div_op_b), .div_rnd_o(div_rnd),
    .div_tag_o(div_tag), .div_valid_i(div_valid), .div_res_i(div_res),
    .div_status_i(div_status), .div_tag_i(div_tag_ret));

  typedef struct packed { logic [31:0] a; logic [31:0] b; logic [2:0] rnd; } op_t;
  typedef struct { int idx; int cyc; } gl_t;

  op_t         opq   [NR][$];
  logic [39:0] exp_q [NR][$];
  gl_t         glog  [$];
  int          total = 0, bad = 0, cyc = 0;
  logic [NR-1:0] last_grant = '0;

  // divider behaviour: two hand-computed IEEE quotients, otherwise a simple mixing function
  function automatic logic [39:0] div_model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rnd);
    if (a == 32'h40C00000 && b == 32'h40000000) return {32'h40400000, 8'h00};
    if (a == 32'h3F800000 && b == 32'h00000000) return {32'h7F800000, 8'h08};
    return {a ^ {b[15:0], b[31:16]}, a[7:0] + b[7:0] + {5'd0, rnd}};
  endfunction

  function automatic op_t mk(input int r, input int k);
    op_t o;
    o.a   = 32'h3000_0000 + 32'(r) * 32'h0100_0000 + 32'(k) * 32'h0001_0101;
    o.b   = 32'h4100_0000 + 32'(k) * 32'd7;
    o.rnd = 3'(k + r);
    return o;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic int cnt(input int m, input int idx);
    int c = 0;
    for (int k = m; k < glog.size(); k++) if (glog[k].idx == idx) c++;
    return c;
  endfunction

  function automatic bit busy();
    bit b = (req_valid != '0);
    for (int i = 0; i < NR; i++) if (opq[i].size() != 0 || exp_q[i].size() != 0) b = 1'b1;
    return b;
  endfunction

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (n < budget && busy()) begin @(negedge clk_i); n++; end
    chk({name, "_drain"}, 64'(n < budget), 64'd1);
  endtask

  task automatic clear_all();
    for (int i = 0; i < NR; i++) begin opq[i].delete(); exp_q[i].delete(); end
    last_grant = '0;
  endtask

  // pipelined divider sharing the reset, so in-flight ops vanish on reset
  logic [L-1:0]  pv;
  logic [39:0]   pd [L];
  logic [IW-1:0] pt [L];
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pv <= '0;
    else begin
      pv    <= {pv[L-2:0], div_en};
      pd[0] <= div_model(div_op_a, div_op_b, div_rnd);
      pt[0] <= div_tag;
      for (int k = 1; k < L; k++) begin pd[k] <= pd[k-1]; pt[k] <= pt[k-1]; end
    end
  end
  assign div_valid   = pv[L-1];
  assign div_res     = pd[L-1][39:8];
  assign div_status  = pd[L-1][7:0];
  assign div_tag_ret = pt[L-1];

  // requester driver: holds the queue head until granted
  initial begin
    req_valid = '0; req_op_a = '0; req_op_b = '0; req_rnd = '0;
    forever begin
      @(posedge clk_i); #1;
      for (int i = 0; i < NR; i++) begin
        if (last_grant[i] && opq[i].size() != 0) void'(opq[i].pop_front());
        if (opq[i].size() != 0) begin
          req_valid[i] = 1'b1;
          req_op_a[i*FW +: FW] = opq[i][0].a;
          req_op_b[i*FW +: FW] = opq[i][0].b;
          req_rnd[i*RW +: RW]  = opq[i][0].rnd;
        end else req_valid[i] = 1'b0;
      end
      last_grant = '0;
    end
  end

  // grant logger: checks the issue mux and pushes the expected response
  initial forever begin
    @(negedge clk_i);
    cyc++;
    if (rst_ni) begin
      if (div_en) begin
        chk("ready_onehot", 64'($onehot(req_ready)), 64'd1);
        for (int i = 0; i < NR; i++) if (req_ready[i]) begin
          chk("grant_has_op", 64'(opq[i].size() != 0), 64'd1);
          chk("div_tag", 64'(div_tag), 64'(i));
          if (opq[i].size() != 0) begin
            chk("div_op_a", 64'(div_op_a), 64'(opq[i][0].a));
            chk("div_op_b", 64'(div_op_b), 64'(opq[i][0].b));
            chk("div_rnd", 64'(div_rnd), 64'(opq[i][0].rnd));
            exp_q[i].push_back(div_model(opq[i][0].a, opq[i][0].b, opq[i][0].rnd));
          end
          glog.push_back('{i, cyc});
          last_grant[i] = 1'b1;
        end
      end else chk("idle_ready", 64'(req_ready), 64'd0);
    end
  end

  // response monitor
  initial forever begin
    logic [39:0] e;
    @(negedge clk_i);
    if (rst_ni) for (int i = 0; i < NR; i++) if (resp_valid[i]) begin
      if (exp_q[i].size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_resp req%0d actual=0x%0h required=none", i, resp_res[i*FW +: FW]);
      end else if (resp_ready[i]) begin
        e = exp_q[i].pop_front();
        chk($sformatf("resp_res%0d", i), 64'(resp_res[i*FW +: FW]), 64'(e[39:8]));
        chk($sformatf("resp_status%0d", i), 64'(resp_status[i*SW +: SW]), 64'(e[7:0]));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, m, lat;
    resp_ready = '1;
    // reset state
    @(negedge clk_i);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_div_en", 64'(div_en), 64'd0);
    chk("rst_resp_res", 64'(resp_res[63:0]), 64'd0);
    chk("rst_resp_status", 64'(resp_status), 64'd0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    // 1: single 6.0/2.0 from req1, latency L+1
    @(negedge clk_i);
    opq[1].push_back('{32'h40C00000, 32'h40000000, 3'd0});
    for (n = 0; n < 20 && !(req_valid[1] && req_ready[1]); n++) @(negedge clk_i);
    chk("t1_ready", 64'(req_ready), 64'b0010);
    chk("t1_tag", 64'(div_tag), 64'd1);
    for (lat = 0; lat < 20 && !resp_valid[1]; lat++) @(negedge clk_i);
    chk("t1_latency", 64'(lat), 64'(L + 1));
    chk("t1_res", 64'(resp_res[FW +: FW]), 64'h40400000);
    chk("t1_status", 64'(resp_status[SW +: SW]), 64'd0);
    wait_idle("t1", 50);

    // 2: everyone busy after reset -> 0,1,2,3,0,... on consecutive cycles
    @(negedge clk_i); rst_ni = 1'b0; #1; clear_all();
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    m = glog.size();
    for (int i = 0; i < NR; i++) for (int k = 0; k < 6; k++) opq[i].push_back(mk(i, k));
    wait_idle("t2", 200);
    chk("t2_grants", 64'(glog.size() - m), 64'd24);
    for (int k = 0; k < 24 && m + k < glog.size(); k++) begin
      chk($sformatf("t2_order%0d", k), 64'(glog[m+k].idx), 64'(k % NR));
      chk($sformatf("t2_cycle%0d", k), 64'(glog[m+k].cyc), 64'(glog[m].cyc + k));
    end

    // 3: req2 blocked on readout -> exactly RES_DEPTH grants, others keep flowing
    @(posedge clk_i); #1; resp_ready = 4'b1011;
    @(negedge clk_i);
    m = glog.size();
    for (int k = 0; k < 4; k++) opq[2].push_back(mk(2, 10 + k));
    for (int k = 0; k < 6; k++) begin
      opq[0].push_back(mk(0, 10 + k)); opq[1].push_back(mk(1, 10 + k)); opq[3].push_back(mk(3, 10 + k));
    end
    repeat (30) @(negedge clk_i);
    chk("t3_req2_grants", 64'(cnt(m, 2)), 64'(RD));
    chk("t3_req0_grants", 64'(cnt(m, 0)), 64'd6);
    chk("t3_req1_grants", 64'(cnt(m, 1)), 64'd6);
    chk("t3_req3_grants", 64'(cnt(m, 3)), 64'd6);
    @(posedge clk_i); #1; resp_ready = 4'b1111;
    @(posedge clk_i); #1; resp_ready = 4'b1011;
    repeat (15) @(negedge clk_i);
    chk("t3_req2_after_pop", 64'(cnt(m, 2)), 64'(RD + 1));
    @(posedge clk_i); #1; resp_ready = 4'b1111;
    wait_idle("t3", 100);

    // 4: credit 1 with grant and pop together -> still exactly one more op fits
    @(posedge clk_i); #1; resp_ready = 4'b1110;
    @(negedge clk_i); opq[0].push_back(mk(0, 50));
    for (n = 0; n < 20 && !resp_valid[0]; n++) @(negedge clk_i);
    chk("t4_first_result", 64'(resp_valid[0]), 64'd1);
    opq[0].push_back(mk(0, 51));
    m = glog.size();
    @(posedge clk_i); #1; resp_ready = 4'b1111;
    @(negedge clk_i);
    chk("t4_grant", 64'(req_ready[0]), 64'd1);
    chk("t4_pop", 64'(resp_valid[0]), 64'd1);
    @(posedge clk_i); #1; resp_ready = 4'b1110;
    @(negedge clk_i);
    opq[0].push_back(mk(0, 52)); opq[0].push_back(mk(0, 53));
    repeat (12) @(negedge clk_i);
    chk("t4_grants_credit1", 64'(cnt(m, 0)), 64'd2);
    @(posedge clk_i); #1; resp_ready = 4'b1111;
    wait_idle("t4", 60);

    // 5: reset with three ops in flight
    @(negedge clk_i);
    m = glog.size();
    for (int i = 0; i < 3; i++) opq[i].push_back(mk(i, 60));
    for (n = 0; n < 20 && glog.size() - m < 3; n++) @(negedge clk_i);
    chk("t5_inflight", 64'(glog.size() - m), 64'd3);
    @(negedge clk_i); rst_ni = 1'b0; #1; clear_all();
    chk("t5_rst_ready", 64'(req_ready), 64'd0);
    chk("t5_rst_div_en", 64'(div_en), 64'd0);
    chk("t5_rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("t5_rst_div_ops", {div_op_a, div_op_b}, 64'd0);
    for (int i = NR - 1; i >= 0; i--) opq[i].push_back(mk(i, 70));
    @(negedge clk_i);
    chk("t5_rst_gated", 64'({req_ready, div_en}), 64'd0);
    rst_ni = 1'b1;
    m = glog.size();
    wait_idle("t5", 60);
    chk("t5_first_grant", 64'(glog.size() > m ? glog[m].idx : 99), 64'd0);

    // 6: 1.0/0.0 from req3, status passes through untouched
    @(negedge clk_i); opq[3].push_back('{32'h3F800000, 32'h00000000, 3'd0});
    for (n = 0; n < 30 && !resp_valid[3]; n++) @(negedge clk_i);
    chk("t6_res", 64'(resp_res[3*FW +: FW]), 64'h7F800000);
    chk("t6_status", 64'(resp_status[3*SW +: SW]), 64'h08);
    wait_idle("t6", 30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
